// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // Arbiter access sequence: choose a winner, perform the access, report completion.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way winner selection. When both requesters are active, the one that
// was not granted last wins. A single active requester always wins.
// "last" = 1 means requester 1 was granted last, so requester 0 is preferred.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

  // Contention goes to the requester that did not win last; otherwise the sole requester wins
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last;
    end else begin
      winner = ~req0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port data-memory arbiter.
// Each access takes three cycles: IDLE (grant pulse), ACCESS (memory cycle),
// DONE (completion pulse). Requests are level-sensitive and looked at only in IDLE.
// Handshake: reqN is held until gntN is seen; gntN pulses for the one IDLE
// cycle in which the request is accepted; doneN pulses exactly two cycles
// later, with rdataN valid while doneN is high for reads.
// Build option: define MEM_ARBITER_FIXED_PRIO_EN to make requester 0 always
// win contention; the round-robin pointer is then not built.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e          state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                win_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                any_req;
  logic                pick;
  logic                last_sel;
  logic                accept;

  assign any_req = req0 | req1;
  assign accept  = (state_q == IDLE) && any_req;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  // Pretending requester 1 always won last makes requester 0 win every contention
  assign last_sel = 1'b1;
`else
  logic last_q;

  // Round-robin pointer: remembers who was granted most recently (reset prefers requester 0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= pick;
    end
  end

  assign last_sel = last_q;
`endif

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_sel),
    .winner (pick)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed three-cycle walk once a request is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the winner's command at grant so later request changes cannot disturb it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      win_q   <= 1'b0;
    end else if (accept) begin
      win_q   <= pick;
      we_q    <= pick ? we1 : we0;
      addr_q  <= pick ? addr1 : addr0;
      wdata_q <= pick ? wdata1 : wdata0;
    end
  end

  // Read data capture at the end of ACCESS; only the winner's register moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if ((state_q == ACCESS) && !we_q) begin
      if (win_q) begin
        rdata1_q <= mem_rdata;
      end else begin
        rdata0_q <= mem_rdata;
      end
    end
  end

  // Output decode: grant in IDLE, memory drive in ACCESS, completion in DONE
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        gnt0 = any_req & ~pick;
        gnt1 = any_req & pick;
      end
      ACCESS: begin
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      DONE: begin
        done0 = ~win_q;
        done1 = win_q;
      end
      default: ;
    endcase
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, data-memory word-address width; DATA_W, default 32, data width.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0/req1  in  1  access request, requester 0/1.
- we0/we1  in  1  1 = write, 0 = read; sampled with addr/wdata at grant.
- addr0/addr1  in  ADDR_W  word address.
- wdata0/wdata1  in  DATA_W  write data.
- gnt0/gnt1  out  1  one-cycle grant pulse.
- done0/done1  out  1  one-cycle completion pulse, reads and writes.
- rdata0/rdata1  out  DATA_W  read data, valid while doneN=1.
- mem_addr  out  ADDR_W  to data memory.
- mem_we  out  1  data-memory write enable.
- mem_wdata  out  DATA_W  to data memory.
- mem_rdata  in  DATA_W  from data memory, combinational read of mem_addr.
REQ-003 The block SHALL have one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS and DONE; every transition SHALL occur on a rising clk edge.
REQ-005 IDLE with any reqN=1: select a winner (REQ-009), pulse gntN for that cycle, latch the winner's we/addr/wdata and the winner index, go to ACCESS.
REQ-006 IDLE with no request: stay in IDLE; all outputs at their reset values.
REQ-007 ACCESS: drive mem_addr/mem_wdata from latches; mem_we = latched we; register mem_rdata into the winner's rdata; go to DONE; mem_we SHALL be high for exactly this one cycle per write.
REQ-008 DONE: pulse the winner's doneN; mem_we=0; go to IDLE. Latency is grant-to-done 2 cycles; one access per 3 cycles.
REQ-009 Round-robin: when both req are high in IDLE, grant the requester not granted last; single requester always wins; after reset, requester 0 has priority.
REQ-010 Requests SHALL be level-sensitive and sampled only in IDLE; reqN changes during ACCESS/DONE have no effect on the access in flight.
REQ-011 A requester dropping reqN before its grant SHALL get no access and no done.
REQ-012 gntN and doneN SHALL never be high for both requesters in the same cycle; gnt and done SHALL never coincide.
REQ-013 For reads, rdataN holds the value captured in ACCESS until that requester's next read completes; the non-winner's rdata SHALL be unchanged.
REQ-014 For writes, done SHALL still pulse; rdata of the winner SHALL be unchanged.
REQ-015 mem_addr/mem_wdata SHALL be 0 outside ACCESS.

Reset
REQ-016 rst=1 SHALL immediately force: state IDLE; gnt0/1, done0/1, mem_we = 0; mem_addr, mem_wdata, rdata0/1 = 0; round-robin pointer = requester 0 preferred.
REQ-017 Reset during ACCESS SHALL drop mem_we asynchronously and abort the access; no done SHALL follow.
REQ-018 Sampling starts on the first rising edge after rst is released.

Configuration
REQ-019 Macro MEM_ARBITER_FIXED_PRIO_EN: when defined, requester 0 SHALL always win contention and the round-robin pointer SHALL be removed; when undefined, REQ-009 applies.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the FSM state enum (IDLE, ACCESS, DONE) and the default ADDR_W/DATA_W constants.
REQ-021 Sub-module rr_pick2 SHALL implement the 2-way winner selection (inputs req0, req1, last; output winner index); the fixed-priority build bypasses its pointer.

Verification
REQ-022 Single read: preload mem[0x0010]=0xDEADBEEF; req0=1, we0=0, addr0=0x0010 -> gnt0 at T, done0 at T+2 with rdata0=0xDEADBEEF.
REQ-023 Single write: req1=1, we1=1, addr1=0x0020, wdata1=0x12345678 -> mem_we=1 only at T+1 with mem_addr=0x0020; done1 at T+2; later read of 0x0020 returns 0x12345678.
REQ-024 Contention: req0=req1=1 held for 4 accesses -> grants alternate 0,1,0,1 (default build); 0,0,0,0 with MEM_ARBITER_FIXED_PRIO_EN.
REQ-025 Reset mid-access: assert rst in ACCESS of a write to 0x0030 -> mem_we falls the same cycle; no done; mem[0x0030] unchanged.
REQ-026 Withdrawn request: req1 pulsed high for 1 cycle while requester 0 is in ACCESS -> no gnt1 and no done1; arbiter returns to IDLE idle.
